// File: rtl/and_32_pkg.sv
// Shared sizing, types and tree-shape helper for the and_32 all-ones detector.
package and32_pkg;

    localparam int AND32_WIDTH = 32;
    localparam int AND32_IDX_W = $clog2(AND32_WIDTH);

    typedef logic [AND32_WIDTH-1:0] and32_vec_t;
    typedef logic [AND32_IDX_W-1:0] and32_idx_t;

    // Number of signals entering tree level `level` (level 0 is the input vector).
    function automatic int and32_level_nodes(input int width, input int fan_in, input int level);
        int n;
        n = width;
        for (int i = 0; i < level; i++) begin
            n = (n + fan_in - 1) / fan_in;
        end
        return n;
    endfunction

endpackage

// File: rtl/and_32_node.sv
// One AND-tree node: FAN_IN-input AND, plus lowest-zero index select when
// AND32_ZERO_IDX_EN is defined.
module and_tree_node #(
    parameter int FAN_IN = 4,
    parameter int IDX_W  = 5
) (
    input  logic [FAN_IN-1:0]            in_bits,
`ifdef AND32_ZERO_IDX_EN
    input  logic [FAN_IN-1:0][IDX_W-1:0] in_idx,
    output logic [IDX_W-1:0]             out_idx,
`endif
    output logic                         out_bit
);

    assign out_bit = &in_bits;

`ifdef AND32_ZERO_IDX_EN
    // Inputs are ordered by bit position, so the lowest zero child carries the lowest zero index.
    always_comb begin
        out_idx = '0;
        for (int k = FAN_IN - 1; k >= 0; k--) begin
            if (in_bits[k] == 1'b0) begin
                out_idx = in_idx[k];
            end
        end
    end
`endif

endmodule

// File: rtl/and_32.sv
// WIDTH-bit AND-reduction with a combinational result and a registered, valid-qualified copy.
// Optional lowest-zero index outputs are enabled by defining AND32_ZERO_IDX_EN.
module and_32
    import and32_pkg::*;
#(
    parameter int WIDTH  = AND32_WIDTH,
    parameter int FAN_IN = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [WIDTH-1:0]          a,
    input  logic                      in_valid,
    output logic                      y,
`ifdef AND32_ZERO_IDX_EN
    output logic [$clog2(WIDTH)-1:0]  zero_idx,
    output logic [$clog2(WIDTH)-1:0]  zero_idx_q,
`endif
    output logic                      y_q,
    output logic                      y_q_valid
);

    localparam int IDX_W = $clog2(WIDTH);

    function automatic int num_levels();
        int n;
        int lv;
        n  = WIDTH;
        lv = 0;
        while (n > 1) begin
            n  = (n + FAN_IN - 1) / FAN_IN;
            lv = lv + 1;
        end
        return lv;
    endfunction

    localparam int LEVELS = num_levels();

    // Each level narrows by FAN_IN; a partially filled node is padded with ones so it cannot mask a zero.
    for (genvar l = 0; l < LEVELS; l++) begin : g_lvl
        localparam int N_IN  = and32_level_nodes(WIDTH, FAN_IN, l);
        localparam int N_OUT = and32_level_nodes(WIDTH, FAN_IN, l + 1);

        logic [N_IN-1:0]  lvl_in;
        logic [N_OUT-1:0] lvl_out;
`ifdef AND32_ZERO_IDX_EN
        logic [N_IN-1:0][IDX_W-1:0]  lvl_in_idx;
        logic [N_OUT-1:0][IDX_W-1:0] lvl_out_idx;
`endif

        if (l == 0) begin : g_src
            assign lvl_in = a;
`ifdef AND32_ZERO_IDX_EN
            for (genvar k = 0; k < N_IN; k++) begin : g_leaf
                assign lvl_in_idx[k] = IDX_W'(k);
            end
`endif
        end else begin : g_src
            assign lvl_in = g_lvl[l-1].lvl_out;
`ifdef AND32_ZERO_IDX_EN
            assign lvl_in_idx = g_lvl[l-1].lvl_out_idx;
`endif
        end

        for (genvar j = 0; j < N_OUT; j++) begin : g_node
            logic [FAN_IN-1:0] node_bits;
`ifdef AND32_ZERO_IDX_EN
            logic [FAN_IN-1:0][IDX_W-1:0] node_idx;
`endif
            for (genvar k = 0; k < FAN_IN; k++) begin : g_in
                if (j * FAN_IN + k < N_IN) begin : g_real
                    assign node_bits[k] = lvl_in[j*FAN_IN+k];
`ifdef AND32_ZERO_IDX_EN
                    assign node_idx[k]  = lvl_in_idx[j*FAN_IN+k];
`endif
                end else begin : g_pad
                    assign node_bits[k] = 1'b1;
`ifdef AND32_ZERO_IDX_EN
                    assign node_idx[k]  = '0;
`endif
                end
            end

            and_tree_node #(
                .FAN_IN (FAN_IN),
                .IDX_W  (IDX_W)
            ) u_node (
                .in_bits (node_bits),
`ifdef AND32_ZERO_IDX_EN
                .in_idx  (node_idx),
                .out_idx (lvl_out_idx[j]),
`endif
                .out_bit (lvl_out[j])
            );
        end
    end

    assign y = g_lvl[LEVELS-1].lvl_out[0];
`ifdef AND32_ZERO_IDX_EN
    assign zero_idx = g_lvl[LEVELS-1].lvl_out_idx[0];
`endif

    logic y_out_d, y_out_q;
    logic y_vld_d, y_vld_q;
`ifdef AND32_ZERO_IDX_EN
    logic [IDX_W-1:0] zidx_d, zidx_q;
`endif

    // Output stage: capture only on in_valid; hold data otherwise but never flag it valid.
    always_comb begin
        y_out_d = y_out_q;
        y_vld_d = in_valid;
`ifdef AND32_ZERO_IDX_EN
        zidx_d  = zidx_q;
`endif
        if (in_valid) begin
            y_out_d = y;
`ifdef AND32_ZERO_IDX_EN
            zidx_d  = zero_idx;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            y_out_q <= 1'b0;
            y_vld_q <= 1'b0;
`ifdef AND32_ZERO_IDX_EN
            zidx_q  <= '0;
`endif
        end else begin
            y_out_q <= y_out_d;
            y_vld_q <= y_vld_d;
`ifdef AND32_ZERO_IDX_EN
            zidx_q  <= zidx_d;
`endif
        end
    end

    assign y_q       = y_out_q;
    assign y_q_valid = y_vld_q;
`ifdef AND32_ZERO_IDX_EN
    assign zero_idx_q = zidx_q;
`endif

endmodule

// File: tb/tb_and_32.sv
// Self-checking bench for and_32: directed cases then biased random vectors against a behavioural model.
// Index outputs are checked when AND32_ZERO_IDX_EN is defined.
module tb_and_32;

    logic        clk;
    logic        rst;
    logic [31:0] a;
    logic        in_valid;
    logic        y;
    logic        y_q;
    logic        y_q_valid;
`ifdef AND32_ZERO_IDX_EN
    logic [4:0]  zero_idx;
    logic [4:0]  zero_idx_q;
`endif

    int checks = 0;
    int errors = 0;

    logic       exp_yq;
    logic       exp_vld;
    logic [4:0] exp_zq;

    and_32 dut (
        .clk        (clk),
        .rst        (rst),
        .a          (a),
        .in_valid   (in_valid),
        .y          (y),
`ifdef AND32_ZERO_IDX_EN
        .zero_idx   (zero_idx),
        .zero_idx_q (zero_idx_q),
`endif
        .y_q        (y_q),
        .y_q_valid  (y_q_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic ref_y(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? 1'b1 : 1'b0;
    endfunction

    function automatic logic [4:0] ref_idx(input logic [31:0] v);
        for (int i = 0; i < 32; i++) begin
            if (v[i] == 1'b0) return 5'(i);
        end
        return 5'd0;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive one cycle, check the combinational path, then the registered path after the edge.
    task automatic step(input logic [31:0] av, input logic v, input logic r);
        @(negedge clk);
        a        = av;
        in_valid = v;
        rst      = r;
        #1;
        check("y_comb", {31'd0, y}, {31'd0, ref_y(av)});
`ifdef AND32_ZERO_IDX_EN
        check("zero_idx_comb", {27'd0, zero_idx}, {27'd0, ref_idx(av)});
`endif
        @(posedge clk);
        if (r) begin
            exp_yq  = 1'b0;
            exp_vld = 1'b0;
            exp_zq  = 5'd0;
        end else if (v) begin
            exp_yq  = ref_y(av);
            exp_vld = 1'b1;
            exp_zq  = ref_idx(av);
        end else begin
            exp_vld = 1'b0;
        end
        #1;
        check("y_q", {31'd0, y_q}, {31'd0, exp_yq});
        check("y_q_valid", {31'd0, y_q_valid}, {31'd0, exp_vld});
`ifdef AND32_ZERO_IDX_EN
        check("zero_idx_q", {27'd0, zero_idx_q}, {27'd0, exp_zq});
`endif
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] v;
        rst      = 1'b1;
        in_valid = 1'b0;
        a        = 32'd0;

        // Combinational path with no edge in between.
        #1;
        a = 32'hFFFF_FFFF; #1;
        check("comb_ones", {31'd0, y}, 32'd1);
        a = 32'h0000_0000; #1;
        check("comb_zero", {31'd0, y}, 32'd0);
        a = 32'hA5A5_A5A5; #1;
        check("comb_a5", {31'd0, y}, 32'd0);
`ifdef AND32_ZERO_IDX_EN
        check("idx_a5", {27'd0, zero_idx}, 32'd1);
        a = 32'h7FFF_FFFF; #1;
        check("idx_7f", {27'd0, zero_idx}, 32'd31);
        a = 32'hFFFF_FFFE; #1;
        check("idx_fe", {27'd0, zero_idx}, 32'd0);
        a = 32'hFFFF_FFFF; #1;
        check("idx_ones", {27'd0, zero_idx}, 32'd0);
`endif

        // Reset for two edges.
        step(32'hFFFF_FFFF, 1'b0, 1'b1);
        step(32'hFFFF_FFFF, 1'b1, 1'b1);
        // Capture, hold without valid, reset beats in_valid.
        step(32'hFFFF_FFFF, 1'b1, 1'b0);
        step(32'h0000_0000, 1'b0, 1'b0);
        step(32'hFFFF_FFFF, 1'b1, 1'b1);
        step(32'hFFFF_FFFF, 1'b1, 1'b0);
        step(32'hFFFF_FFFE, 1'b1, 1'b0);
        step(32'h7FFF_FFFF, 1'b1, 1'b0);
        step(32'hA5A5_A5A5, 1'b1, 1'b0);
        step(32'h0000_0000, 1'b1, 1'b0);

        // Single zero walked through every bit, back-to-back valid.
        for (int i = 0; i < 32; i++) begin
            v = 32'hFFFF_FFFF;
            v[i] = 1'b0;
            step(v, 1'b1, 1'b0);
        end

        // Biased random vectors.
        for (int n = 0; n < 1000; n++) begin
            if ($urandom_range(0, 1) == 0) begin
                v = 32'hFFFF_FFFF;
                if ($urandom_range(0, 1) == 1) v[$urandom_range(0, 31)] = 1'b0;
            end else begin
                v = $urandom;
            end
            step(v, 1'($urandom_range(0, 1)), ($urandom_range(0, 49) == 0) ? 1'b1 : 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
